// File: rtl/pipeline_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and pipeline_ctrl (slave).
interface pipeline_ctrl_if;
   logic [4:0]  rs1_addrD;
   logic [4:0]  rs2_addrD;
   logic [4:0]  rs1_addrE;
   logic [4:0]  rs2_addrE;
   logic [4:0]  rd_addrE;
   logic        rd_wrenE;
   logic [1:0]  wb_selE;
   logic [4:0]  rd_addrM;
   logic        rd_wrenM;
   logic [4:0]  rd_addrW;
   logic        rd_wrenW;
   logic        br_takenE;
   logic        mem_reqM;
   logic        mem_ackM;
   logic        stallF;
   logic        stallD;
   logic        stallE;
   logic        stallM;
   logic        flushD;
   logic        flushE;
   logic        clrW;
   logic [1:0]  fwd_aE;
   logic [1:0]  fwd_bE;
   logic        err;
   logic [15:0] stall_cnt;

   modport master (
      output rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE, rd_addrE, rd_wrenE, wb_selE,
             rd_addrM, rd_wrenM, rd_addrW, rd_wrenW, br_takenE, mem_reqM, mem_ackM,
      input  stallF, stallD, stallE, stallM, flushD, flushE, clrW, fwd_aE, fwd_bE,
             err, stall_cnt
   );

   modport slave (
      input  rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE, rd_addrE, rd_wrenE, wb_selE,
             rd_addrM, rd_wrenM, rd_addrW, rd_wrenW, br_takenE, mem_reqM, mem_ackM,
      output stallF, stallD, stallE, stallM, flushD, flushE, clrW, fwd_aE, fwd_bE,
             err, stall_cnt
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use bubbles, branch flushes
// and memory-wait stalls with a timeout that locks into a sticky error state.
module pipeline_ctrl #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [1:0]  LOAD_SEL = 2'b01
) (
   input logic            clk,
   input logic            rst,
   pipeline_ctrl_if.slave bus
);

   typedef enum logic [1:0] {RUN, MEMWAIT, ERR} state_t;

   state_t      state;
   state_t      state_next;
   logic [7:0]  wait_cnt;
   logic [15:0] stall_cnt_q;
   logic        err_q;

   logic        mem_wait;
   logic        load_use;
   logic        wait_expired;
   logic        stall_f;
   logic        stall_d;
   logic        stall_e;
   logic        stall_m;
   logic        flush_d;
   logic        flush_e;
   logic        clr_w;
   logic [1:0]  fwd_a;
   logic [1:0]  fwd_b;

   // M stage is younger than W, so its result wins when both target the operand.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] rd_m, input logic wren_m,
                                          input logic [4:0] rd_w, input logic wren_w);
      logic [1:0] sel;
      sel = 2'b00;
      if (rs != 5'd0 && wren_m && rd_m == rs)
         sel = 2'b10;
      else if (rs != 5'd0 && wren_w && rd_w == rs)
         sel = 2'b01;
      return sel;
   endfunction

   always_comb begin
      state_next   = state;
      stall_f      = 1'b0;
      stall_d      = 1'b0;
      stall_e      = 1'b0;
      stall_m      = 1'b0;
      flush_d      = 1'b0;
      flush_e      = 1'b0;
      clr_w        = 1'b0;
      fwd_a        = 2'b00;
      fwd_b        = 2'b00;

      mem_wait     = ((state == RUN) && bus.mem_reqM && !bus.mem_ackM) ||
                     ((state == MEMWAIT) && !bus.mem_ackM);
      load_use     = (bus.wb_selE == LOAD_SEL) && bus.rd_wrenE && (bus.rd_addrE != 5'd0) &&
                     ((bus.rd_addrE == bus.rs1_addrD) || (bus.rd_addrE == bus.rs2_addrD));
      // Checked against the post-increment value so TIMEOUT unacked MEMWAIT cycles trip it.
      wait_expired = ({1'b0, wait_cnt} + 9'd1) >= 9'(TIMEOUT);

      case (state)
         RUN:     if (mem_wait) state_next = MEMWAIT;
         MEMWAIT: begin
            if (bus.mem_ackM)
               state_next = RUN;
            else if (wait_expired)
               state_next = ERR;
         end
         ERR:     state_next = ERR;
         default: state_next = RUN;
      endcase

      if (!rst) begin
         fwd_a = fwd_sel(bus.rs1_addrE, bus.rd_addrM, bus.rd_wrenM, bus.rd_addrW, bus.rd_wrenW);
         fwd_b = fwd_sel(bus.rs2_addrE, bus.rd_addrM, bus.rd_wrenM, bus.rd_addrW, bus.rd_wrenW);
         if (state == ERR || mem_wait) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            clr_w   = 1'b1;
         end else if (bus.br_takenE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
         end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
         end
      end
   end

   // wait_cnt cannot wrap: TIMEOUT <= 255 forces ERR before it reaches 8'hFF + 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         wait_cnt    <= 8'd0;
         stall_cnt_q <= 16'd0;
         err_q       <= 1'b0;
      end else begin
         state <= state_next;
         if (state == RUN && state_next == MEMWAIT)
            wait_cnt <= 8'd0;
         else if (state == MEMWAIT && !bus.mem_ackM)
            wait_cnt <= wait_cnt + 8'd1;
         if (stall_f && stall_cnt_q != 16'hFFFF)
            stall_cnt_q <= stall_cnt_q + 16'd1;
         err_q <= err_q | (state_next == ERR);
      end
   end

   assign bus.stallF    = stall_f;
   assign bus.stallD    = stall_d;
   assign bus.stallE    = stall_e;
   assign bus.stallM    = stall_m;
   assign bus.flushD    = flush_d;
   assign bus.flushE    = flush_e;
   assign bus.clrW      = clr_w;
   assign bus.fwd_aE    = fwd_a;
   assign bus.fwd_bE    = fwd_b;
   assign bus.err       = err_q;
   assign bus.stall_cnt = stall_cnt_q;

endmodule
